sort_loader: RTL and testbench

SORT_LOADER -- requirements
Module: sort_loader

---
 rtl/sort_loader.sv | 115 +++++++++++
 tb/tb_sort_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_loader.sv
// Collects BEATS input beats into one TOTAL_NUM-key vector, launches the sort
// engine, then waits for its completion before accepting the next job.
module sort_loader #(
  parameter int TOTAL_NUM  = 1024,
  parameter int BEAT_WORDS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_req,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BEAT_WORDS*32-1:0]  in_data,
  input  logic                      in_last,
  output logic                      sort_start,
  input  logic                      sort_done,
  output logic [TOTAL_NUM*32-1:0]   input_data,
  output logic                      busy,
  output logic                      job_done,
  output logic                      len_err
);

  localparam int BEATS     = TOTAL_NUM / BEAT_WORDS;
  localparam int CNT_W     = $clog2(BEATS) + 1;
  localparam int BEAT_BITS = BEAT_WORDS * 32;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [CNT_W-1:0]        beat_cnt_r;
  logic                    job_done_r;
  logic                    len_err_r;
  logic [TOTAL_NUM*32-1:0] input_data_r;
  logic                    accept_s;
  logic                    last_beat_s;
  logic                    len_bad_s;

  assign accept_s    = (state_r == FILL) && in_valid;
  assign last_beat_s = (beat_cnt_r == LAST_BEAT);
  // Length is wrong when in_last disagrees with the beat position.
  assign len_bad_s   = (in_last != last_beat_s);

  // Next-state decode; sort_done is only honoured in WAIT.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_req) state_nx_s = FILL;
        else          state_nx_s = IDLE;
      end
      FILL: begin
        if (accept_s) begin
          if (last_beat_s)  state_nx_s = START;
          else if (in_last) state_nx_s = IDLE;
          else              state_nx_s = FILL;
        end else begin
          state_nx_s = FILL;
        end
      end
      START: state_nx_s = WAIT;
      WAIT: begin
        if (sort_done) state_nx_s = IDLE;
        else           state_nx_s = WAIT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, beat counter, completion pulse and sticky length error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      beat_cnt_r <= '0;
      job_done_r <= 1'b0;
      len_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      job_done_r <= (state_r == WAIT) && sort_done;
      if ((state_r == IDLE) && load_req) begin
        beat_cnt_r <= '0;
        len_err_r  <= 1'b0;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
        if (len_bad_s) len_err_r <= 1'b1;
      end
    end
  end

  // Key vector: each accepted beat lands in its own slot, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      input_data_r <= '0;
    end else if (accept_s) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_cnt_r == CNT_W'(k)) begin
          input_data_r[k*BEAT_BITS +: BEAT_BITS] <= in_data;
        end
      end
    end
  end

  assign in_ready   = (state_r == FILL);
  assign sort_start = (state_r == START);
  assign busy       = (state_r != IDLE);
  assign job_done   = job_done_r;
  assign len_err    = len_err_r;
  assign input_data = input_data_r;

endmodule

// File: tb/tb_sort_loader.sv
// Directed, table-driven bench for sort_loader with a simple key-vector model.
module tb_sort_loader;

  localparam int TOTAL_NUM  = 1024;
  localparam int BEAT_WORDS = 16;
  localparam int BEATS      = TOTAL_NUM / BEAT_WORDS;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      load_req;
  logic                      in_valid;
  logic                      in_ready;
  logic [BEAT_WORDS*32-1:0]  in_data;
  logic                      in_last;
  logic                      sort_start;
  logic                      sort_done;
  logic [TOTAL_NUM*32-1:0]   input_data;
  logic                      busy;
  logic                      job_done;
  logic                      len_err;

  always #5 clk = ~clk;

  sort_loader #(.TOTAL_NUM(TOTAL_NUM), .BEAT_WORDS(BEAT_WORDS)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .sort_start(sort_start), .sort_done(sort_done), .input_data(input_data),
    .busy(busy), .job_done(job_done), .len_err(len_err)
  );

  typedef struct {
    int last_at;      // beat carrying in_last, -1 for none
    int max_gap;      // idle cycles between beats, 0..max_gap
    int key_base;     // key of word 0 of beat 0
    int wait_cycles;  // engine latency in WAIT before sort_done
    bit exp_len_err;
    int exp_starts;
  } job_t;

  job_t        vec [4];
  job_t        hj;
  logic [31:0] exp_mem [TOTAL_NUM];
  int cmp_cnt = 0;
  int fail_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int exp_start_total = 0;
  int exp_done_total = 0;

  // Pulse counters sampled on the active edge (pre-edge values).
  always @(posedge clk) begin
    if (sort_start) start_cnt <= start_cnt + 1;
    if (job_done)   done_cnt  <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name);
    int bad = 0;
    int first = -1;
    for (int w = 0; w < TOTAL_NUM; w++) begin
      if (input_data[w*32 +: 32] !== exp_mem[w]) begin
        bad++;
        if (first < 0) first = w;
      end
    end
    if (bad != 0) $display("  %s: first bad word %0d", name, first);
    chk(name, 64'(bad), 64'd0);
  endtask

  task automatic send_beat(input int b, input int base, input bit last);
    logic [BEAT_WORDS*32-1:0] beat;
    for (int j = 0; j < BEAT_WORDS; j++) begin
      beat[j*32 +: 32]         = 32'(base + b*BEAT_WORDS + j);
      exp_mem[b*BEAT_WORDS + j] = 32'(base + b*BEAT_WORDS + j);
    end
    in_valid = 1'b1;
    in_data  = beat;
    in_last  = last;
    tick;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Request, fill, and check up to the cycle after the final beat.
  task automatic run_job(input job_t v);
    int nb = (v.last_at < 0) ? BEATS : v.last_at + 1;
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    chk("fill_in_ready", in_ready, 1);
    chk("fill_busy", busy, 1);
    chk("len_err_cleared", len_err, 0);
    for (int b = 0; b < nb; b++) begin
      int gap = (v.max_gap > 0) ? int'($urandom_range(0, v.max_gap)) : 0;
      repeat (gap) tick;
      send_beat(b, v.key_base, b == v.last_at);
    end
    if (v.exp_starts != 0) begin
      chk("start_latency", sort_start, 1);
      chk("in_ready_start", in_ready, 0);
      chk("busy_start", busy, 1);
    end else begin
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_no_start", sort_start, 0);
    end
    chk("len_err", len_err, 64'(v.exp_len_err));
    chk_data("data_fill");
    exp_start_total += v.exp_starts;
    if (v.exp_starts == 0) begin
      tick;
      chk("start_count_abort", 64'(start_cnt), 64'(exp_start_total));
    end
  endtask

  // From the START cycle: enter WAIT, model engine latency, check job_done.
  task automatic finish_job(input int delay, input bit poke);
    int stray = 0;
    tick;
    chk("wait_busy", busy, 1);
    chk("no_done_from_start", job_done, 0);
    chk("start_one_cycle", sort_start, 0);
    sort_done = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) load_req = 1'b1;
      tick;
      load_req = 1'b0;
      if (poke && i == 0) begin
        chk("wait_load_ignored_ready", in_ready, 0);
        chk("wait_load_ignored_busy", busy, 1);
      end
      if (job_done !== 1'b0 || busy !== 1'b1) stray++;
    end
    chk("wait_hold", 64'(stray), 64'd0);
    sort_done = 1'b1;
    tick;
    sort_done = 1'b0;
    chk("job_done_pulse", job_done, 1);
    chk("idle_after_done", busy, 0);
    exp_done_total++;
    tick;
    chk("job_done_one_cycle", job_done, 0);
    chk("done_count", 64'(done_cnt), 64'(exp_done_total));
    chk("start_count", 64'(start_cnt), 64'(exp_start_total));
    chk_data("data_held");
  endtask

  initial begin
    vec[0] = '{63, 0, 0,    0, 1'b0, 1};   // contiguous, key = index
    vec[1] = '{63, 5, 0,    4, 1'b0, 1};   // bursty valid
    vec[2] = '{-1, 1, 5000, 2, 1'b1, 1};   // in_last missing on final beat
    vec[3] = '{10, 0, 100,  0, 1'b1, 0};   // in_last early on beat 10

    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; sort_done = 1'b0;
    for (int w = 0; w < TOTAL_NUM; w++) exp_mem[w] = 32'd0;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sort_start", sort_start, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_len_err", len_err, 0);
    chk_data("rst_data");
    rst = 1'b0;
    tick;

    for (int i = 0; i < 4; i++) begin
      run_job(vec[i]);
      if (i == 0) begin
        chk("word0", input_data[31:0], 0);
        chk("word1023", input_data[32767:32736], 1023);
      end
      if (vec[i].exp_starts != 0) finish_job(vec[i].wait_cycles, 1'b0);
    end

    // Sticky len_err cleared by reset while idle.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_clears_len_err", len_err, 0);
    for (int w = 0; w < TOTAL_NUM; w++) exp_mem[w] = 32'd0;
    chk_data("rst_idle_data");

    // Stale sort_done through START, long engine latency, load_req in WAIT.
    sort_done = 1'b1;
    hj = '{63, 0, 20000, 1025, 1'b0, 1};
    run_job(hj);
    finish_job(1025, 1'b1);

    // Back-to-back request, then reset arriving with beat 30.
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    chk("b2b_fill", in_ready, 1);
    for (int b = 0; b < 30; b++) send_beat(b, 7000, 1'b0);
    rst = 1'b1;
    send_beat(30, 7000, 1'b0);
    rst = 1'b0;
    for (int w = 0; w < TOTAL_NUM; w++) exp_mem[w] = 32'd0;
    chk("fill_rst_busy", busy, 0);
    chk("fill_rst_in_ready", in_ready, 0);
    chk("fill_rst_start", sort_start, 0);
    chk("fill_rst_done", job_done, 0);
    chk("fill_rst_len_err", len_err, 0);
    chk_data("fill_rst_data");
    repeat (3) tick;
    chk("fill_rst_no_start", 64'(start_cnt), 64'(exp_start_total));
    hj = '{63, 0, 9000, 2, 1'b0, 1};
    run_job(hj);
    finish_job(2, 1'b0);

    // Reset coinciding with sort_done in WAIT: no job_done may follow.
    hj = '{63, 0, 11000, 0, 1'b0, 1};
    run_job(hj);
    tick;
    chk("wait_rst_pre_busy", busy, 1);
    sort_done = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("wait_rst_done", job_done, 0);
    chk("wait_rst_busy", busy, 0);
    tick;
    chk("wait_rst_done_after", job_done, 0);
    sort_done = 1'b0;
    tick;
    chk("wait_rst_done_count", 64'(done_cnt), 64'(exp_done_total));
    chk("wait_rst_start_count", 64'(start_cnt), 64'(exp_start_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
